// File: rtl/term_loopback_tile_if.sv
// Fabric-edge bundle: configuration chain plus loopback wires of one tile.
interface term_loopback_tile_if #(
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned NUM_CH          = 16
);
    logic [FrameBitsPerRow-1:0] FrameData;
    logic [FrameBitsPerRow-1:0] FrameData_O;
    logic [MaxFramesPerCol-1:0] FrameStrobe;
    logic [MaxFramesPerCol-1:0] FrameStrobe_O;
    logic [NUM_CH-1:0]          LoopIn;
    logic [NUM_CH-1:0]          LoopOut;
    logic [2*NUM_CH-1:0]        CfgActive;

    // Fabric / neighbour side: drives config and incoming wires.
    modport master (
        output FrameData, FrameStrobe, LoopIn,
        input  FrameData_O, FrameStrobe_O, LoopOut, CfgActive
    );

    // Tile side.
    modport slave (
        input  FrameData, FrameStrobe, LoopIn,
        output FrameData_O, FrameStrobe_O, LoopOut, CfgActive
    );
endinterface

// File: rtl/term_loopback_tile.sv
// Fabric-edge termination tile: per-channel loopback with frame-loaded,
// glitch-free applied modes (tie-off / comb / 1-stage / 2-stage).
module term_loopback_tile #(
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned NUM_CH          = 16,
    parameter int unsigned CFG_FRAME       = 0
) (
    input  logic UserCLK,
    input  logic UserRST,
    output logic UserCLKo,
    term_loopback_tile_if.slave bus
);
    localparam int unsigned CfgW = 2 * NUM_CH;

    // Reject parameter sets whose mode frame cannot fit or be strobed.
    if (CfgW > FrameBitsPerRow) begin : g_bad_width
        $error("term_loopback_tile: 2*NUM_CH exceeds FrameBitsPerRow");
    end
    if (CFG_FRAME >= MaxFramesPerCol) begin : g_bad_frame
        $error("term_loopback_tile: CFG_FRAME out of FrameStrobe range");
    end

    logic [CfgW-1:0]   shadow;
    logic [CfgW-1:0]   active;
    logic              strb_q;
    logic [NUM_CH-1:0] stage1;
    logic [NUM_CH-1:0] stage2;

    logic              strobe_c;
    logic              commit_c;
    logic [NUM_CH-1:0] stage1_d_c;
    logic [NUM_CH-1:0] stage2_d_c;
    logic [NUM_CH-1:0] loop_out_c;

    // Neighbour pass-through, untouched by reset.
    assign UserCLKo          = UserCLK;
    assign bus.FrameData_O   = bus.FrameData;
    assign bus.FrameStrobe_O = bus.FrameStrobe;

    // Commit fires on the cycle after the strobe falls.
    assign strobe_c = bus.FrameStrobe[CFG_FRAME];
    assign commit_c = strb_q & ~strobe_c;

    // Stage next values: flush on mode change, idle modes hold zero.
    always_comb begin
        stage1_d_c = '0;
        stage2_d_c = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (!(commit_c && (shadow[2*i +: 2] != active[2*i +: 2]))) begin
                if (active[2*i+1]) begin
                    stage1_d_c[i] = bus.LoopIn[i];
                end
                if (active[2*i +: 2] == 2'b11) begin
                    stage2_d_c[i] = stage1[i];
                end
            end
        end
    end

    // Config shadow/active registers and loopback pipeline.
    always_ff @(posedge UserCLK) begin
        if (UserRST) begin
            shadow <= '0;
            active <= '0;
            strb_q <= 1'b0;
            stage1 <= '0;
            stage2 <= '0;
        end else begin
            if (strobe_c) begin
                shadow <= bus.FrameData[CfgW-1:0];
            end
            if (commit_c) begin
                active <= shadow;
            end
            strb_q <= strobe_c;
            stage1 <= stage1_d_c;
            stage2 <= stage2_d_c;
        end
    end

    // Per-channel output select from the applied mode.
    always_comb begin
        loop_out_c = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            case (active[2*i +: 2])
                2'b01:   loop_out_c[i] = bus.LoopIn[i];
                2'b10:   loop_out_c[i] = stage1[i];
                2'b11:   loop_out_c[i] = stage2[i];
                default: loop_out_c[i] = 1'b0;
            endcase
        end
    end

    assign bus.LoopOut   = loop_out_c;
    assign bus.CfgActive = active;
endmodule

// File: tb/tb_term_loopback_tile.sv
// Scoreboard bench for term_loopback_tile, mode frame on the last strobe index.
module tb_term_loopback_tile;
    localparam int unsigned MAXF  = 20;
    localparam int unsigned FBITS = 32;
    localparam int unsigned NCH   = 16;
    localparam int unsigned CFG   = 19;

    typedef struct {
        logic [NCH-1:0]   lo;
        logic [2*NCH-1:0] ca;
        logic [FBITS-1:0] fdo;
        logic [MAXF-1:0]  fso;
    } exp_t;

    logic UserCLK;
    logic UserRST;
    logic UserCLKo;

    term_loopback_tile_if #(
        .MaxFramesPerCol(MAXF), .FrameBitsPerRow(FBITS), .NUM_CH(NCH)
    ) bus ();

    term_loopback_tile #(
        .MaxFramesPerCol(MAXF), .FrameBitsPerRow(FBITS),
        .NUM_CH(NCH), .CFG_FRAME(CFG)
    ) dut (
        .UserCLK (UserCLK),
        .UserRST (UserRST),
        .UserCLKo(UserCLKo),
        .bus     (bus)
    );

    initial begin
        UserCLK = 1'b0;
        forever #5 UserCLK = ~UserCLK;
    end

    int n_checks = 0;
    int n_errors = 0;
    exp_t sb_q[$];

    // Reference state, written from the behavioural description.
    logic [2*NCH-1:0] m_shadow = '0;
    logic [2*NCH-1:0] m_active = '0;
    logic             m_strbq  = 1'b0;
    logic [NCH-1:0]   m_h1     = '0;
    logic [NCH-1:0]   m_h2     = '0;
    int               m_age [NCH];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive, predict, sample at negedge, advance the model.
    task automatic drive_cycle(input logic rst, input logic [FBITS-1:0] fd,
                               input logic [MAXF-1:0] fs, input logic [NCH-1:0] li);
        exp_t e;
        exp_t g;
        logic [1:0] m;
        logic strobe;
        logic commit;
        UserRST         = rst;
        bus.FrameData   = fd;
        bus.FrameStrobe = fs;
        bus.LoopIn      = li;

        e.lo = '0;
        for (int c = 0; c < int'(NCH); c++) begin
            m = m_active[2*c +: 2];
            case (m)
                2'd1:    e.lo[c] = li[c];
                2'd2:    e.lo[c] = (m_age[c] >= 1) ? m_h1[c] : 1'b0;
                2'd3:    e.lo[c] = (m_age[c] >= 2) ? m_h2[c] : 1'b0;
                default: e.lo[c] = 1'b0;
            endcase
        end
        e.ca  = m_active;
        e.fdo = fd;
        e.fso = fs;
        sb_q.push_back(e);

        @(negedge UserCLK);
        g = sb_q.pop_front();
        check("LoopOut",       64'(bus.LoopOut),       64'(g.lo));
        check("CfgActive",     64'(bus.CfgActive),     64'(g.ca));
        check("FrameData_O",   64'(bus.FrameData_O),   64'(g.fdo));
        check("FrameStrobe_O", 64'(bus.FrameStrobe_O), 64'(g.fso));
        check("UserCLKo",      64'(UserCLKo),          64'(UserCLK));

        if (rst) begin
            m_shadow = '0;
            m_active = '0;
            m_strbq  = 1'b0;
            for (int c = 0; c < int'(NCH); c++) m_age[c] = 0;
        end else begin
            strobe = fs[CFG];
            commit = m_strbq && !strobe;
            for (int c = 0; c < int'(NCH); c++) begin
                if (commit && (m_shadow[2*c +: 2] != m_active[2*c +: 2])) m_age[c] = 0;
                else if (m_age[c] < 3) m_age[c]++;
            end
            if (commit) m_active = m_shadow;
            if (strobe) m_shadow = fd[2*NCH-1:0];
            m_strbq = strobe;
        end
        m_h2 = m_h1;
        m_h1 = li;

        @(posedge UserCLK);
        #1;
    endtask

    localparam logic [MAXF-1:0] STB   = MAXF'(1) << CFG;
    localparam logic [MAXF-1:0] NOISE = MAXF'(1);

    initial begin
        logic [NCH-1:0]   li;
        logic [MAXF-1:0]  fs;
        logic [FBITS-1:0] fd;
        logic             rst;
        for (int c = 0; c < int'(NCH); c++) m_age[c] = 0;
        UserRST         = 1'b1;
        bus.FrameData   = '0;
        bus.FrameStrobe = '0;
        bus.LoopIn      = '1;
        @(posedge UserCLK);
        #1;

        // Reset holds outputs low while pass-through tracks.
        drive_cycle(1'b1, 32'hA5A5_0F0F, '0, 16'hFFFF);
        drive_cycle(1'b1, 32'h1234_5678, NOISE, 16'hFFFF);

        // Mode mix 0,1,2,3 repeating, then walking one; off-index strobe ignored.
        drive_cycle(1'b0, 32'hE4E4_E4E4, STB, 16'h0000);
        drive_cycle(1'b0, 32'h0000_0000, '0, 16'h0000);
        for (int i = 0; i < 20; i++) begin
            li = NCH'(1) << (i % int'(NCH));
            drive_cycle(1'b0, (i == 5) ? 32'hFFFF_FFFF : 32'h0, (i == 5) ? NOISE : '0, li);
        end

        // Last captured frame wins; commit one cycle after the fall.
        drive_cycle(1'b0, 32'h1111_1111, STB, 16'hAAAA);
        drive_cycle(1'b0, 32'h2222_2222, STB, 16'h5555);
        drive_cycle(1'b0, 32'h3333_3333, STB, 16'hF0F0);
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 32'h0, '0, NCH'(i * 16'h1357));

        // Flush: ch2 10 -> 11 while its input is high, ch3 unchanged.
        drive_cycle(1'b0, 32'hE4E4_E4E4, STB, 16'hFFFF);
        for (int i = 0; i < 5; i++) drive_cycle(1'b0, 32'h0, '0, 16'hFFFF);
        drive_cycle(1'b0, 32'hE4E4_E4F4, STB, 16'hFFFF);
        for (int i = 0; i < 5; i++) drive_cycle(1'b0, 32'h0, '0, 16'hFFFF);

        // Reset before the fall discards the uncommitted shadow.
        drive_cycle(1'b1, 32'h0, '0, 16'hFFFF);
        drive_cycle(1'b0, 32'h5555_5555, STB, 16'hFFFF);
        drive_cycle(1'b0, 32'h5555_5555, STB, 16'hFFFF);
        drive_cycle(1'b1, 32'h5555_5555, STB, 16'hFFFF);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 32'h0, '0, 16'hFFFF);

        // Strobe held through reset release: capture resumes, all channels 2-stage.
        drive_cycle(1'b1, 32'hFFFF_FFFF, STB, 16'h1234);
        drive_cycle(1'b0, 32'hFFFF_FFFF, STB, 16'h4321);
        for (int i = 0; i < 6; i++) drive_cycle(1'b0, 32'h0, '0, NCH'($urandom));

        // Random traffic with sporadic frames and resets.
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            fs  = MAXF'($urandom) & ~STB;
            if ($urandom_range(0, 4) == 0) fs = fs | STB;
            fd  = FBITS'($urandom);
            li  = NCH'($urandom);
            drive_cycle(rst, fd, fs, li);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
